rx_pkt_filter: RTL and testbench
================================

Name: rx_pkt_filter

Overview:
Store-and-forward Ethernet receive filter placed between the MAC receive AXI-Stream (8-bit) and the image block's rx_axis input. It buffers each incoming frame and strips the fixed header. Only frames with no error, the correct EtherType and the exact image-packet length are forwarded as a single payload frame. Bad, foreign, mis-sized or overflowing frames are discarded completely, so the downstream packet assembler only ever sees clean 132-byte packets.

Parameters:
HDR_LEN, 14, header bytes stripped from the start of each frame
PKT_LEN, 132, required payload bytes per frame
ETHERTYPE, 16'h88B5, required value of header bytes 12 (MSB) and 13 (LSB)
DEPTH, 512, payload buffer depth in bytes; power of two, at least PKT_LEN+1
AW, 9, log2(DEPTH)

Ports:
clk  in  1  rx_fifo_clock domain clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  8  MAC receive byte
s_axis_tvalid  in  1  byte valid
s_axis_tlast  in  1  last byte of frame
s_axis_tuser  in  1  frame error, sampled with tlast
s_axis_tready  out  1  always 1 outside reset; the MAC cannot be stalled
m_axis_tdata  out  8  payload byte to the image block
m_axis_tvalid  out  1  payload valid
m_axis_tlast  out  1  last payload byte (byte PKT_LEN)
m_axis_tready  in  1  downstream ready
frm_ok_cnt  out  16  frames forwarded, saturating
frm_drop_cnt  out  16  frames dropped (any reason), saturating
ovf_flag  out  1  sticky; set when any frame is dropped for buffer overflow

Behaviour:
- Reset: all pointers, counters, byte index, frame flags and ovf_flag are 0; s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0. s_axis_tready goes to 1 the cycle after rst deasserts.
- Buffer: circular RAM of DEPTH x 9 bits {last, data}. Pointers wr_ptr, commit_ptr and rd_ptr are AW+1 bits wide (wrap bit). Full when the addresses are equal and the wrap bits differ. Empty when rd_ptr == commit_ptr.
- Write side:
  - An 11-bit byte index counts bytes in the current frame and saturates at 2047.
  - Bytes 12 and 13 are compared against ETHERTYPE; a mismatch sets bad_type.
  - Bytes with index >= HDR_LEN are written at wr_ptr and wr_ptr increments. The last bit is written as 1 only when the byte is payload byte PKT_LEN.
  - If the buffer is full at a write, the byte is not written and the frame's ovf bit is set.
- Frame end (s_axis_tvalid & s_axis_tlast):
  - The frame is good iff tuser=0, bad_type=0, ovf=0 and the total byte count equals HDR_LEN+PKT_LEN.
  - Good frame: commit_ptr <= wr_ptr (including the tlast byte's write, if any) and frm_ok_cnt+1.
  - Bad frame: wr_ptr <= commit_ptr (rewind) and frm_drop_cnt+1. If the frame's ovf bit is set, ovf_flag <= 1.
  - The byte index and frame flags clear for the next frame, which may begin on the very next cycle.
- Read side:
  - Synchronous RAM read followed by a 1-entry output register plus a skid, so streaming is full-rate.
  - First m_axis_tvalid is no later than 3 cycles after commit_ptr advances.
  - A byte transfers on m_axis_tvalid & m_axis_tready. tdata and tlast hold stable while tvalid=1 and tready=0.
  - No bubbles while bytes are committed and m_axis_tready=1.
- Simultaneous commit and read in the same cycle: both take effect. The read may only consume bytes that were committed before that cycle.
- Full is evaluated against rd_ptr. The old rd_ptr is used when a read and a write occur in the same cycle, which is conservative.
- Uncommitted bytes are never visible on m_axis. A dropped frame leaves no trace downstream.
- rst asserted mid-frame or mid-readout: all state returns to reset values. Any partial frame in flight is lost, with no count increment. The input side resynchronises at the next frame start: bytes seen before the first tlast after reset are treated as a frame and will fail the length check unless they happen to be a complete frame.

Test Plan:
- Good frame: 146 bytes, bytes 12/13 = 88/B5, payload 0x12..0x95, tuser=0, m_axis_tready=1 -> exactly 132 bytes out, equal to 0x12..0x95, tlast only on 0x95; frm_ok_cnt=1.
- Error and mismatch frames: one 146-byte frame with tuser=1 at tlast, one 145-byte frame, one 147-byte frame and one frame with EtherType 0800 -> no m_axis_tvalid at all; frm_drop_cnt=4; frm_ok_cnt unchanged.
- Back-pressure and back-to-back frames: three good frames sent back-to-back while m_axis_tready toggles with a random 50% duty -> 396 bytes out, in order, with tlast every 132 bytes; data stable during every stall.
- Overflow (DEPTH=256): m_axis_tready=0 and two good frames sent -> first committed, second dropped; ovf_flag=1, frm_drop_cnt=1. Then release tready -> exactly 132 bytes from the first frame.
- Interleaved good and bad frames: good, bad (tuser), good -> exactly 264 bytes out, with no bytes from the bad frame appearing between the two good payloads.
- Reset mid-stream: rst pulsed during byte 70 of a good frame and again during readout -> outputs and counters return to 0. The next complete good frame is forwarded correctly.

Source files
------------

// File: rtl/rx_pkt_filter_if.sv
// rx_pkt_filter_if: 8-bit AXI-Stream byte channel
interface rx_pkt_filter_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;
    modport master(output tdata, tvalid, tlast, tuser, input tready);
    modport slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_pkt_filter.sv
// rx_pkt_filter: store-and-forward frame filter that strips the header and forwards only clean image packets
module rx_pkt_filter #(
    parameter int          HDR_LEN   = 14,
    parameter int          PKT_LEN   = 132,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          DEPTH     = 512,
    parameter int          AW        = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    rx_pkt_filter_if.slave        s_axis,
    rx_pkt_filter_if.master       m_axis,
    output logic [15:0]           frm_ok_cnt,
    output logic [15:0]           frm_drop_cnt,
    output logic                  ovf_flag
);
    localparam int FRM_LEN = HDR_LEN + PKT_LEN;
    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, commit_ptr, rd_ptr, wr_ptr_n;
    logic [10:0] idx;
    logic        bad_type, ovf, in_v, pay, full, empty, wr, ovf_now, eop, good, mism, is_last;
    logic [8:0]  ram_q, skid;
    logic        ram_v, skid_v, pop, rd_en, head_free;
    logic [1:0]  pend;
    assign in_v      = s_axis.tvalid & s_axis.tready;
    assign pay       = idx >= 11'(HDR_LEN);
    assign is_last   = idx == 11'(FRM_LEN - 1);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty     = rd_ptr == commit_ptr;
    assign wr        = in_v & pay & ~full;
    assign ovf_now   = in_v & pay & full;
    assign wr_ptr_n  = wr_ptr + (AW+1)'(wr);
    assign eop       = in_v & s_axis.tlast;
    assign mism      = (idx == 11'd12 && s_axis.tdata != ETHERTYPE[15:8]) ||
                       (idx == 11'd13 && s_axis.tdata != ETHERTYPE[7:0]);
    assign good      = ~s_axis.tuser & ~bad_type & ~ovf & ~ovf_now & is_last;
    assign pop       = m_axis.tvalid & m_axis.tready;
    assign head_free = ~m_axis.tvalid | m_axis.tready;
    // head + skid + in-flight RAM read never exceed the two output slots
    assign pend      = 2'(m_axis.tvalid) + 2'(skid_v) + 2'(ram_v) - 2'(pop);
    assign rd_en     = ~empty & (pend < 2'd2);
    assign m_axis.tuser = 1'b0;
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr[AW-1:0]] <= {is_last, s_axis.tdata};
        if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axis.tready <= 1'b0;
            idx           <= '0;
            bad_type      <= 1'b0;
            ovf           <= 1'b0;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            rd_ptr        <= '0;
            frm_ok_cnt    <= '0;
            frm_drop_cnt  <= '0;
            ovf_flag      <= 1'b0;
            ram_v         <= 1'b0;
            skid_v        <= 1'b0;
            skid          <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tdata  <= '0;
        end else begin
            s_axis.tready <= 1'b1;
            if (in_v) begin
                idx      <= eop ? '0 : idx + 11'(idx != 11'h7FF);
                bad_type <= ~eop & (bad_type | mism);
                ovf      <= ~eop & (ovf | ovf_now);
            end
            wr_ptr <= eop ? (good ? wr_ptr_n : commit_ptr) : wr_ptr_n;
            if (eop & good) commit_ptr <= wr_ptr_n;
            frm_ok_cnt   <= frm_ok_cnt + 16'(eop & good & (frm_ok_cnt != 16'hFFFF));
            frm_drop_cnt <= frm_drop_cnt + 16'(eop & ~good & (frm_drop_cnt != 16'hFFFF));
            if (eop & ~good & (ovf | ovf_now)) ovf_flag <= 1'b1;
            rd_ptr <= rd_ptr + (AW+1)'(rd_en);
            ram_v  <= rd_en;
            if (head_free) begin
                m_axis.tvalid <= skid_v | ram_v;
                if (skid_v) {m_axis.tlast, m_axis.tdata} <= skid;
                else if (ram_v) {m_axis.tlast, m_axis.tdata} <= ram_q;
                skid_v <= skid_v & ram_v;
                if (skid_v & ram_v) skid <= ram_q;
            end else if (ram_v) begin
                skid   <= ram_q;
                skid_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rx_pkt_filter.sv
// tb_rx_pkt_filter: directed checks of forwarding, filtering, back-pressure, overflow and reset
module tb_rx_pkt_filter;
    logic clk = 0, rst = 1;
    logic [7:0] sd = 0;
    logic sv = 0, sl = 0, su = 0, sel = 0;
    logic rdy_a = 0, rdy_b = 0;
    int mode_a = 1, mode_b = 0;
    int n_chk = 0, n_err = 0;
    logic [8:0] rx_a[$], rx_b[$], exp_q[$];
    logic stall_a = 0, stall_b = 0;
    logic [8:0] held_a, held_b;
    logic [15:0] ok_a, drop_a, ok_b, drop_b;
    logic ovf_a, ovf_b;
    rx_pkt_filter_if s_a(), m_a(), s_b(), m_b();
    assign s_a.tdata = sd;
    assign s_a.tvalid = sv & ~sel;
    assign s_a.tlast = sl;
    assign s_a.tuser = su;
    assign s_b.tdata = sd;
    assign s_b.tvalid = sv & sel;
    assign s_b.tlast = sl;
    assign s_b.tuser = su;
    assign m_a.tready = rdy_a;
    assign m_b.tready = rdy_b;
    rx_pkt_filter dut_a (.clk(clk), .rst(rst), .s_axis(s_a), .m_axis(m_a),
                         .frm_ok_cnt(ok_a), .frm_drop_cnt(drop_a), .ovf_flag(ovf_a));
    rx_pkt_filter #(.DEPTH(256), .AW(8)) dut_b (.clk(clk), .rst(rst), .s_axis(s_b), .m_axis(m_b),
                         .frm_ok_cnt(ok_b), .frm_drop_cnt(drop_b), .ovf_flag(ovf_b));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    always @(negedge clk) begin
        rdy_a = mode_a == 2 ? 1'($urandom_range(0, 1)) : mode_a[0];
        rdy_b = mode_b[0];
        if (!rst) begin
            if (stall_a) check("stall_a", {m_a.tlast, m_a.tdata}, held_a);
            if (stall_b) check("stall_b", {m_b.tlast, m_b.tdata}, held_b);
            if (m_a.tvalid && rdy_a) rx_a.push_back({m_a.tlast, m_a.tdata});
            if (m_b.tvalid && rdy_b) rx_b.push_back({m_b.tlast, m_b.tdata});
            stall_a = m_a.tvalid && !rdy_a;
            stall_b = m_b.tvalid && !rdy_b;
            held_a = {m_a.tlast, m_a.tdata};
            held_b = {m_b.tlast, m_b.tdata};
        end else begin
            stall_a = 0;
            stall_b = 0;
        end
    end
    task automatic send_frame(input int len, input logic [15:0] et, input logic err,
                              input logic [7:0] base, input int rst_at);
        for (int i = 0; i < len; i++) begin
            sd = i < 12 ? 8'(8'hA0 + i) : i == 12 ? et[15:8] : i == 13 ? et[7:0] : 8'(base + (i - 14));
            sv = 1;
            sl = i == len - 1;
            su = err && i == len - 1;
            if (i == rst_at) rst = 1;
            @(negedge clk);
            if (i == rst_at) break;
        end
        sv = 0;
        sl = 0;
        su = 0;
    endtask
    task automatic good(input logic [7:0] base);
        send_frame(146, 16'h88B5, 0, base, -1);
    endtask
    task automatic add_exp(input logic [7:0] base);
        for (int k = 0; k < 132; k++) exp_q.push_back({k == 131, 8'(base + k)});
    endtask
    task automatic wait_rx(input logic b, input int n);
        for (int k = 0; k < 3000 && (b ? rx_b.size() : rx_a.size()) < n; k++) @(negedge clk);
        repeat (20) @(negedge clk);
    endtask
    task automatic check_stream(input string tag, input logic b);
        check({tag, "_len"}, b ? rx_b.size() : rx_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < (b ? rx_b.size() : rx_a.size()))
                check($sformatf("%s_byte%0d", tag, i), b ? rx_b[i] : rx_a[i], exp_q[i]);
        exp_q.delete();
        rx_a.delete();
        rx_b.delete();
    endtask
    task automatic check_reset_state(input string tag);
        check({tag, "_tvalid"}, m_a.tvalid, 0);
        check({tag, "_tdata"}, m_a.tdata, 0);
        check({tag, "_tlast"}, m_a.tlast, 0);
        check({tag, "_tready"}, s_a.tready, 0);
        check({tag, "_ok"}, ok_a, 0);
        check({tag, "_drop"}, drop_a, 0);
        check({tag, "_ovf"}, ovf_a, 0);
    endtask
    initial begin
        repeat (4) @(negedge clk);
        check_reset_state("rst");
        rst = 0;
        @(negedge clk);
        check("tready_up", s_a.tready, 1);
        good(8'h12);
        add_exp(8'h12);
        wait_rx(0, 132);
        check_stream("good", 0);
        check("good_ok", ok_a, 1);
        send_frame(146, 16'h88B5, 1, 8'h40, -1);
        send_frame(145, 16'h88B5, 0, 8'h40, -1);
        send_frame(147, 16'h88B5, 0, 8'h40, -1);
        send_frame(146, 16'h0800, 0, 8'h40, -1);
        repeat (300) @(negedge clk);
        check("bad_out", rx_a.size(), 0);
        check("bad_drop", drop_a, 4);
        check("bad_ok", ok_a, 1);
        mode_a = 2;
        good(8'h20);
        good(8'h40);
        good(8'h60);
        add_exp(8'h20);
        add_exp(8'h40);
        add_exp(8'h60);
        wait_rx(0, 396);
        check_stream("b2b", 0);
        check("b2b_ok", ok_a, 4);
        mode_a = 1;
        good(8'h01);
        send_frame(146, 16'h88B5, 1, 8'hC0, -1);
        good(8'h05);
        add_exp(8'h01);
        add_exp(8'h05);
        wait_rx(0, 264);
        check_stream("mix", 0);
        check("mix_ok", ok_a, 6);
        check("mix_drop", drop_a, 5);
        send_frame(146, 16'h88B5, 0, 8'h70, 70);
        @(negedge clk);
        check_reset_state("rst_frame");
        rst = 0;
        repeat (2) @(negedge clk);
        good(8'h22);
        for (int k = 0; k < 500 && rx_a.size() < 50; k++) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        check_reset_state("rst_read");
        rst = 0;
        repeat (2) @(negedge clk);
        rx_a.delete();
        good(8'h33);
        add_exp(8'h33);
        wait_rx(0, 132);
        check_stream("post_rst", 0);
        check("post_rst_ok", ok_a, 1);
        check("post_rst_drop", drop_a, 0);
        sel = 1;
        good(8'h10);
        good(8'h50);
        repeat (10) @(negedge clk);
        check("ovf_tvalid", m_b.tvalid, 1);
        check("ovf_tdata", m_b.tdata, 8'h10);
        check("ovf_flag", ovf_b, 1);
        check("ovf_drop", drop_b, 1);
        check("ovf_ok", ok_b, 1);
        mode_b = 1;
        add_exp(8'h10);
        wait_rx(1, 132);
        check_stream("ovf", 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
